uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per serial bit period (legal range 4..65535).
REQ-002 The module SHALL have input clk, 1 bit, the system clock; all logic on its rising edge.
REQ-003 The module SHALL have input rst, 1 bit, a synchronous, active-high reset.
REQ-004 The module SHALL have input rx, 1 bit, the asynchronous serial line: 8N1, LSB first, idle high.
REQ-005 The module SHALL have input fifo_full, 1 bit, the downstream byte FIFO full flag.
REQ-006 The module SHALL have output wr_en, 1 bit, a one-cycle write strobe to the downstream FIFO.
REQ-007 The module SHALL have output data_out, 8 bits, the received byte; valid while wr_en=1.
REQ-008 The module SHALL have output frame_err, 1 bit, a one-cycle pulse when the stop bit samples low.
REQ-009 The module SHALL have output overrun, 1 bit, a one-cycle pulse when a good byte is dropped because fifo_full=1.
REQ-010 The module SHALL have output busy, 1 bit, high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1) to form rx_s; all logic uses rx_s only.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK.
REQ-013 In IDLE, rx_s=0 SHALL move the FSM to START with the bit counter cleared.
REQ-014 In START, after CLKS_PER_BIT/2 cycles (integer division), the FSM SHALL sample rx_s: 0 -> DATA with the counter cleared; 1 -> IDLE (glitch rejected, no output).
REQ-015 In DATA, every CLKS_PER_BIT cycles the FSM SHALL sample rx_s into shift register bit index 0..7 (LSB first); after the 8th sample it SHALL go to STOP.
REQ-016 In STOP, after CLKS_PER_BIT cycles the FSM SHALL sample rx_s:
- 1 with fifo_full=0 -> wr_en=1 for exactly the next cycle, with data_out = the assembled byte;
- 1 with fifo_full=1 -> overrun=1 for one cycle, wr_en stays 0, byte discarded;
- 0 -> frame_err=1 for one cycle, no write, move to BREAK.
REQ-017 After a good stop bit the FSM SHALL return to IDLE in the same cycle wr_en or overrun asserts, so a start bit immediately following is accepted.
REQ-018 In BREAK, the FSM SHALL stay until rx_s=1, then go to IDLE.
REQ-019 fifo_full SHALL be sampled only at the stop-bit sample cycle.
REQ-020 wr_en, frame_err and overrun SHALL be mutually exclusive and never high for more than one consecutive cycle per byte.
REQ-021 data_out SHALL hold its last value between strobes.
REQ-022 Counters SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and SHALL NOT wrap within a bit period.
REQ-023 Latency from the rx falling edge of the start bit to wr_en SHALL be 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for edge alignment).

Reset
REQ-024 When rst=1, on the next clk edge: state=IDLE, counters=0, shift register=0, data_out=0x00, wr_en=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-byte SHALL abandon the byte with no strobe; the first frame starting after rst deasserts SHALL be received correctly.

Verification (CLKS_PER_BIT=4)
REQ-026 Send 0xA5 with fifo_full=0 -> exactly one wr_en pulse with data_out=0xA5; frame_err=0, overrun=0.
REQ-027 Send back-to-back 0x00 then 0xFF with no idle gap -> two wr_en pulses with data 0x00 then 0xFF.
REQ-028 1-cycle low glitch on idle rx -> busy returns to 0 within 4 cycles; no wr_en, no frame_err.
REQ-029 Send 0x3C with stop bit low, then hold rx low for 20 bit periods -> one frame_err pulse, no wr_en, busy=1 until rx goes high, then the next 0x55 frame is received correctly.
REQ-030 Send 0x7E with fifo_full=1 at the stop sample -> one overrun pulse, no wr_en; repeat with fifo_full=0 -> wr_en with 0x7E.
REQ-031 Assert rst during DATA bit 3 of 0x81 -> all outputs 0 the next cycle; no strobe for that byte; the following 0x81 frame -> wr_en with data_out=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle high. It samples each bit in the middle and
// emits a one-cycle write strobe toward a byte FIFO. A low stop bit is reported as
// a framing error and parks the receiver until the line returns high. A good byte
// that arrives while the FIFO is full is dropped and flagged as an overrun.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       wr_en,
  output logic [7:0] data_out,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  // Last count before the mid-start sample and before each full-bit sample.
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              rx_meta_q, rx_s;
  logic              stop_tick;

  // Two-flop synchronizer; it resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // FSM state register and receive datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: bit timing, data sampling and frame sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StBreak;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Output decode: the stop-bit sample selects write, overrun or framing error.
  always_comb begin
    stop_tick   = (state_q == StStop) && (cnt_q == BitLast);
    wr_en_d     = stop_tick && rx_s && !fifo_full;
    overrun_d   = stop_tick && rx_s && fifo_full;
    frame_err_d = stop_tick && !rx_s;
    data_d      = wr_en_d ? shift_q : data_q;
  end

  // Registered strobes so each pulse lasts exactly one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      data_q      <= data_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign data_out  = data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at four clocks per bit. Each frame sent pushes its
// expected outcome (write/frame error/overrun) to a queue. A monitor pops an entry
// for every strobe the receiver raises.
module tb_uart_rx;

  localparam int Cpb = 4;

  typedef struct {
    int         kind;  // 0 write, 1 frame error, 2 overrun
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       fifo_full;
  logic       wr_en;
  logic [7:0] data_out;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int  tests_run    = 0;
  int  tests_failed = 0;
  int  writes_seen  = 0;
  int  frames_seen  = 0;
  int  overs_seen   = 0;
  ev_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .fifo_full(fifo_full),
    .wr_en    (wr_en),
    .data_out (data_out),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Inputs change 1 time unit after a rising edge and hold for a full bit.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected outcome.
  initial begin
    ev_t e;
    int  kind;
    logic prev_any;
    logic any;
    prev_any = 1'b0;
    forever begin
      @(negedge clk);
      any = wr_en | frame_err | overrun;
      if (any) begin
        check("strobe_exclusive", 32'($countones({wr_en, frame_err, overrun})), 32'd1);
        check("strobe_single_cycle", 32'(prev_any), 32'd0);
        kind = wr_en ? 0 : (frame_err ? 1 : 2);
        if (kind == 0) writes_seen++;
        else if (kind == 1) frames_seen++;
        else overs_seen++;
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_kind", 32'(kind), 32'(e.kind));
          if (kind == 0) check("write_data", 32'(data_out), 32'(e.data));
        end
      end
      prev_any = any;
    end
  end

  initial begin
    logic seen;
    rst       = 1'b1;
    rx        = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // Single good byte.
    expect_ev(0, 8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(8);
    check("hold_a5", 32'(data_out), 32'hA5);

    // Back-to-back frames with no idle gap.
    expect_ev(0, 8'h00);
    expect_ev(0, 8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(8);
    check("hold_ff", 32'(data_out), 32'hFF);
    check("idle_busy_after_b2b", 32'(busy), 32'd0);

    // One-cycle low glitch: start detection then rejection at mid-bit.
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_rise", 32'(seen), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check("glitch_busy_fall", 32'(seen), 32'd1);
    idle(6);

    // Framing error followed by a long break, then a good frame.
    expect_ev(1, 8'h00);
    send_byte(8'h3C, 1'b0);
    repeat (20 * Cpb) @(posedge clk);
    @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("break_release_busy", 32'(busy), 32'd0);
    check("hold_after_ferr", 32'(data_out), 32'hFF);
    idle(4);
    expect_ev(0, 8'h55);
    send_byte(8'h55, 1'b1);
    idle(8);

    // Overrun while the FIFO is full, then the same byte accepted.
    fifo_full = 1'b1;
    expect_ev(2, 8'h00);
    send_byte(8'h7E, 1'b1);
    idle(8);
    fifo_full = 1'b0;
    check("hold_after_overrun", 32'(data_out), 32'h55);
    expect_ev(0, 8'h7E);
    send_byte(8'h7E, 1'b1);
    idle(8);

    // Reset in the middle of data bit 3 of 0x81.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'h00);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    expect_ev(0, 8'h81);
    send_byte(8'h81, 1'b1);
    idle(10);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("writes_total", 32'(writes_seen), 32'd6);
    check("frame_errs_total", 32'(frames_seen), 32'd1);
    check("overruns_total", 32'(overs_seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
